// File: rtl/reg_file_flush_if.sv
// Bus bundle between decode/ALU and the flushable register file: write port,
// two read ports, global enable and the flush handshake.
interface reg_file_flush_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              En;
  logic              WE;
  logic [ADDR_W-1:0] WAddr;
  logic [WIDTH-1:0]  D;
  logic [ADDR_W-1:0] RAddrA;
  logic [ADDR_W-1:0] RAddrB;
  logic [WIDTH-1:0]  QA;
  logic [WIDTH-1:0]  QB;
  logic              Flush;
  logic              Busy;
  logic              Done;

  modport master (
    output En, WE, WAddr, D, RAddrA, RAddrB, Flush,
    input  QA, QB, Busy, Done
  );

  modport slave (
    input  En, WE, WAddr, D, RAddrA, RAddrB, Flush,
    output QA, QB, Busy, Done
  );
endinterface

// File: rtl/reg_file_flush.sv
// Parametrised register file: one write port, two bypassed combinational read
// ports, global enable, and a one-entry-per-cycle flush sequencer.
module reg_file_flush #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             CLK,
  input logic             CLR_n,
  reg_file_flush_if.slave rf
);

  localparam logic [0:0]        IDLE     = 1'b0;
  localparam logic [0:0]        FLUSH    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nx;
  logic              done;
  logic              done_nx;
  logic              wr_ok;
  logic              clr_ok;

  // Addresses can encode more codes than there are entries when DEPTH is not
  // a power of two; those codes read as zero and never write.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  always_comb begin
    wr_ok  = rf.En && rf.WE && (state == IDLE) && in_range(rf.WAddr);
    clr_ok = rf.En && (state == FLUSH);
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    done_nx  = 1'b0;
    if (rf.En) begin
      case (state)
        IDLE: begin
          if (rf.Flush) begin
            state_nx = FLUSH;
            ptr_nx   = '0;
          end
        end
        FLUSH: begin
          if (ptr == LAST_PTR) begin
            state_nx = IDLE;
            ptr_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            ptr_nx = ptr + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      done  <= done_nx;
    end
  end

  // The write port and the flush sequencer are mutually exclusive by state.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (wr_ok) begin
      mem[rf.WAddr] <= rf.D;
    end else if (clr_ok) begin
      mem[ptr] <= RESET_VAL;
    end
  end

  assign rf.QA = (wr_ok && (rf.RAddrA == rf.WAddr)) ? rf.D :
                 in_range(rf.RAddrA) ? mem[rf.RAddrA] : '0;
  assign rf.QB = (wr_ok && (rf.RAddrB == rf.WAddr)) ? rf.D :
                 in_range(rf.RAddrB) ? mem[rf.RAddrB] : '0;

  assign rf.Busy = (state == FLUSH);
  assign rf.Done = done;

endmodule

// File: tb/tb_reg_file_flush.sv
// Self-checking bench for reg_file_flush: directed vector table, flush corner
// sequences, a DEPTH=6 instance, and random traffic against a reference model.
module tb_reg_file_flush;

  localparam int DEPTH  = 8;
  localparam int DEPTH6 = 6;

  typedef struct {
    bit         en;
    bit         we;
    logic [2:0] wa;
    logic [7:0] d;
    logic [2:0] ra;
    logic [2:0] rb;
    bit         fl;
    logic [7:0] qa;
    logic [7:0] qb;
    bit         busy;
    bit         done;
  } vec_t;

  logic CLK = 1'b0;
  logic CLR_n;

  always #5 CLK = ~CLK;

  reg_file_flush_if #(.WIDTH(8), .ADDR_W(3)) rf ();
  reg_file_flush_if #(.WIDTH(8), .ADDR_W(3)) rf6 ();

  reg_file_flush #(.WIDTH(8), .DEPTH(DEPTH), .ADDR_W(3), .RESET_VAL(8'h00)) dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .rf    (rf)
  );

  reg_file_flush #(.WIDTH(8), .DEPTH(DEPTH6), .ADDR_W(3), .RESET_VAL(8'h00)) dut6 (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .rf    (rf6)
  );

  int checks = 0;
  int passed = 0;
  int busy_seen;
  int done_seen;
  logic [7:0] last_qa, last_qb;
  logic       last_busy, last_done;

  // Reference model: entry contents plus how many entries a flush still owes.
  logic [7:0] m [DEPTH];
  int         flush_left;
  bit         done_m;

  vec_t vec [9];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    flush_left = 0;
    done_m     = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a, input bit en, input bit we,
                                           input logic [2:0] wa, input logic [7:0] d);
    if (en && we && flush_left == 0 && wa == a && int'(wa) < DEPTH) return d;
    if (int'(a) < DEPTH) return m[a];
    return 8'h00;
  endfunction

  task automatic model_edge(input bit en, input bit we, input logic [2:0] wa,
                            input logic [7:0] d, input bit fl);
    if (!en) begin
      done_m = 1'b0;
    end else if (flush_left == 0) begin
      done_m = 1'b0;
      if (we && int'(wa) < DEPTH) m[wa] = d;
      if (fl) flush_left = DEPTH;
    end else begin
      m[DEPTH - flush_left] = 8'h00;
      flush_left--;
      done_m = (flush_left == 0);
    end
  endtask

  // Called on a falling edge; checks outputs before the next rising edge.
  task automatic applyStimulus(input bit en, input bit we, input logic [2:0] wa,
                               input logic [7:0] d, input logic [2:0] ra,
                               input logic [2:0] rb, input bit fl);
    rf.En = en; rf.WE = we; rf.WAddr = wa; rf.D = d;
    rf.RAddrA = ra; rf.RAddrB = rb; rf.Flush = fl;
    #1;
    last_qa = rf.QA; last_qb = rf.QB; last_busy = rf.Busy; last_done = rf.Done;
    checkOutput("QA", rf.QA, model_read(ra, en, we, wa, d));
    checkOutput("QB", rf.QB, model_read(rb, en, we, wa, d));
    checkOutput("Busy", 8'(rf.Busy), 8'(flush_left != 0));
    checkOutput("Done", 8'(rf.Done), 8'(done_m));
    checkOutput("done_busy_excl", 8'(rf.Done & rf.Busy), 8'h00);
    if (rf.Busy) busy_seen++;
    if (rf.Done) done_seen++;
    @(posedge CLK);
    model_edge(en, we, wa, d, fl);
    @(negedge CLK);
  endtask

  task automatic fill_all(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 1'b1, 3'(i), 8'(base + 8'(i) * 8'h11), 3'(i), 3'((i + 7) % 8), 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec[0] = '{1'b1, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b1, 3'd4, 8'h5C, 3'd3, 3'd4, 1'b0, 8'hA5, 8'h5C, 1'b0, 1'b0};
    vec[3] = '{1'b0, 1'b1, 3'd2, 8'h3C, 3'd2, 3'd4, 1'b0, 8'h00, 8'h5C, 1'b0, 1'b0};
    vec[4] = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vec[5] = '{1'b1, 1'b1, 3'd2, 8'h3C, 3'd2, 3'd2, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vec[6] = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd7, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0};
    vec[7] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd2, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0};
    vec[8] = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd2, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0};

    // Power-on reset
    CLR_n = 1'b0;
    rf.En = 1'b1; rf.WE = 1'b0; rf.WAddr = 3'd0; rf.D = 8'h00;
    rf.RAddrA = 3'd3; rf.RAddrB = 3'd5; rf.Flush = 1'b0;
    rf6.En = 1'b1; rf6.WE = 1'b0; rf6.WAddr = 3'd0; rf6.D = 8'h00;
    rf6.RAddrA = 3'd0; rf6.RAddrB = 3'd0; rf6.Flush = 1'b0;
    model_reset();
    busy_seen = 0; done_seen = 0;
    #2;
    checkOutput("reset_QA", rf.QA, 8'h00);
    checkOutput("reset_QB", rf.QB, 8'h00);
    checkOutput("reset_Busy", 8'(rf.Busy), 8'h00);
    checkOutput("reset_Done", 8'(rf.Done), 8'h00);
    @(negedge CLK);
    CLR_n = 1'b1;

    // Directed write/read/bypass/enable vectors
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vec[i].en, vec[i].we, vec[i].wa, vec[i].d, vec[i].ra, vec[i].rb, vec[i].fl);
      checkOutput($sformatf("vec%0d_QA", i), last_qa, vec[i].qa);
      checkOutput($sformatf("vec%0d_QB", i), last_qb, vec[i].qb);
      checkOutput($sformatf("vec%0d_Busy", i), 8'(last_busy), 8'(vec[i].busy));
      checkOutput($sformatf("vec%0d_Done", i), 8'(last_done), 8'(vec[i].done));
    end

    // DEPTH=6 instance: out-of-range write/read, bypass at the top entry, short flush
    rf.En = 1'b0; rf.WE = 1'b0; rf.Flush = 1'b0;
    rf6.WE = 1'b1; rf6.WAddr = 3'd7; rf6.D = 8'h77; rf6.RAddrA = 3'd7; rf6.RAddrB = 3'd5;
    #1;
    checkOutput("d6_oor_no_bypass", rf6.QA, 8'h00);
    @(posedge CLK); @(negedge CLK);
    rf6.WAddr = 3'd5; rf6.D = 8'h55; rf6.RAddrA = 3'd5; rf6.RAddrB = 3'd7;
    #1;
    checkOutput("d6_bypass_top", rf6.QA, 8'h55);
    checkOutput("d6_oor_read", rf6.QB, 8'h00);
    @(posedge CLK); @(negedge CLK);
    rf6.WE = 1'b0;
    for (int i = 0; i < DEPTH6; i++) begin
      rf6.RAddrA = 3'(i);
      #1;
      checkOutput($sformatf("d6_entry%0d", i), rf6.QA, (i == 5) ? 8'h55 : 8'h00);
    end
    rf6.Flush = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rf6.Flush = 1'b0;
    busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rf6.Busy) busy_seen++;
      if (rf6.Done) done_seen++;
      @(posedge CLK); @(negedge CLK);
    end
    checkOutput("d6_flush_busy_cycles", 8'(busy_seen), 8'd6);
    checkOutput("d6_flush_done_pulses", 8'(done_seen), 8'd1);
    rf6.RAddrA = 3'd5;
    #1;
    checkOutput("d6_flushed_top", rf6.QA, 8'h00);

    // Plain flush of a full file
    fill_all(8'h11);
    busy_seen = 0; done_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b1);
    for (int j = 0; j < 10; j++)
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'(j % 8), 3'(7 - (j % 8)), 1'b0);
    checkOutput("flush_busy_cycles", 8'(busy_seen), 8'd8);
    checkOutput("flush_done_pulses", 8'(done_seen), 8'd1);

    // Flush+WE same cycle, WE while busy, and a 3-cycle En stall mid-flush
    fill_all(8'h20);
    busy_seen = 0; done_seen = 0;
    applyStimulus(1'b1, 1'b1, 3'd7, 8'h5A, 3'd7, 3'd7, 1'b1);
    checkOutput("flush_we_bypass", last_qa, 8'h5A);
    for (int j = 0; j < 12; j++)
      applyStimulus(!(j >= 3 && j < 6), (j == 6), 3'd1, 8'hEE,
                    (j == 6) ? 3'd1 : 3'd7, 3'(j % 8), 1'b0);
    checkOutput("stall_busy_cycles", 8'(busy_seen), 8'd11);
    checkOutput("stall_done_pulses", 8'(done_seen), 8'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd7, 1'b0);
    checkOutput("we_in_busy_dropped", last_qa, 8'h00);
    checkOutput("flush_we_cleared", last_qb, 8'h00);

    // Reset while the flush pointer sits at 4
    fill_all(8'h31);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b1);
    for (int j = 0; j < 4; j++)
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b0);
    rf.En = 1'b1; rf.WE = 1'b0; rf.Flush = 1'b0; rf.RAddrA = 3'd5; rf.RAddrB = 3'd7;
    #1;
    CLR_n = 1'b0;
    #1;
    checkOutput("midflush_reset_QA", rf.QA, 8'h00);
    checkOutput("midflush_reset_QB", rf.QB, 8'h00);
    checkOutput("midflush_reset_Busy", 8'(rf.Busy), 8'h00);
    checkOutput("midflush_reset_Done", 8'(rf.Done), 8'h00);
    model_reset();
    #1;
    CLR_n = 1'b1;
    @(negedge CLK);
    done_seen = 0;
    for (int j = 0; j < 10; j++)
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'(j % 8), 3'(7 - (j % 8)), 1'b0);
    checkOutput("midflush_no_done", 8'(done_seen), 8'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++)
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 15) == 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
